// File: rtl/spi_rx.sv
// SPI receive deserializer: samples sclk/rxd/cs_n in the clk domain, assembles
// words of programmable width and emits them on a single-entry AXI-Stream master.
module spi_rx #(
    parameter int AXIS_DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       rxd,
    input  logic                       cs_n,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    input  logic [1:0]                 spi_mode,
    input  logic [5:0]                 spi_word_width,
    output logic                       busy,
    output logic                       overflow,
    output logic                       frame_error
);

    localparam int         DW  = AXIS_DATA_WIDTH;
    localparam logic [6:0] DW7 = 7'(DW);

    // Receive state is carried by bit_cnt; the enum names it for checkers.
    typedef enum logic {IDLE, RECV} rx_state_t;
    rx_state_t rx_state;

    // Handshake: a word transfers on any clk edge where m_axis_tvalid and
    // m_axis_tready are both high; tvalid never drops and tdata never changes
    // while the word is held without tready.

    logic sclk_s1, sclk_s2, sclk_s3;
    logic rxd_s1, rxd_s2, rxd_s3;
    logic cs_s1, cs_s2;

    logic [5:0]    bit_cnt, bit_cnt_d;
    logic [6:0]    w_reg, w_d;
    logic [DW-1:0] shift_reg, shift_d;
    logic          word_done, done_d;
    logic          fe_pend, fe_d;
    logic [DW-1:0] tdata_d;
    logic          tvalid_d, ovf_d;

    logic       sample_rise, sample_fall, sample_edge;
    logic [6:0] ww7, w_new, w_cur, cnt_next7;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
            rxd_s1  <= 1'b0; rxd_s2  <= 1'b0; rxd_s3  <= 1'b0;
            cs_s1   <= 1'b0; cs_s2   <= 1'b0;
        end else begin
            sclk_s1 <= sclk;    sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
            rxd_s1  <= rxd;     rxd_s2  <= rxd_s1;  rxd_s3  <= rxd_s2;
            cs_s1   <= cs_n;    cs_s2   <= cs_s1;
        end
    end

    assign sample_rise = sclk_s2 & ~sclk_s3;
    assign sample_fall = ~sclk_s2 & sclk_s3;
    // Modes 1 and 2 sample on the falling edge, modes 0 and 3 on the rising one.
    assign sample_edge = (spi_mode[0] ^ spi_mode[1]) ? sample_fall : sample_rise;

    assign ww7       = {1'b0, spi_word_width};
    assign w_new     = (ww7 == 7'd0 || ww7 > DW7) ? DW7 : ww7;
    assign w_cur     = (bit_cnt == 6'd0) ? w_new : w_reg;
    assign cnt_next7 = {1'b0, bit_cnt} + 7'd1;

    assign rx_state = (bit_cnt == 6'd0) ? IDLE : RECV;
    assign busy     = (rx_state == RECV);

    always_comb begin
        bit_cnt_d = bit_cnt;
        w_d       = w_reg;
        shift_d   = shift_reg;
        done_d    = 1'b0;
        fe_d      = 1'b0;
        if (cs_s2) begin
            bit_cnt_d = 6'd0;
            fe_d      = (rx_state == RECV);
        end else if (sample_edge) begin
            if (rx_state == IDLE) begin
                w_d     = w_new;
                shift_d = {{(DW-1){1'b0}}, rxd_s3};
            end else begin
                shift_d = {shift_reg[DW-2:0], rxd_s3};
            end
            if (cnt_next7 == w_cur) begin
                bit_cnt_d = 6'd0;
                done_d    = 1'b1;
            end else begin
                bit_cnt_d = cnt_next7[5:0];
            end
        end
    end

    // Completion is registered one cycle before the output stage sees it.
    always_comb begin
        tdata_d  = m_axis_tdata;
        tvalid_d = m_axis_tvalid;
        ovf_d    = 1'b0;
        if (word_done) begin
            if (!m_axis_tvalid || m_axis_tready) begin
                tdata_d  = shift_reg;
                tvalid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= 6'd0;
            w_reg         <= DW7;
            shift_reg     <= '0;
            word_done     <= 1'b0;
            fe_pend       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overflow      <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            bit_cnt       <= bit_cnt_d;
            w_reg         <= w_d;
            shift_reg     <= shift_d;
            word_done     <= done_d;
            fe_pend       <= fe_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tvalid <= tvalid_d;
            overflow      <= ovf_d;
            frame_error   <= fe_pend;
        end
    end

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: an 8-bit and a 16-bit instance share the serial lines and
// have separate chip selects; received words are scored against a width model.
module tb_spi_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        rxd = 1'b0;
    logic        cs_n8 = 1'b1;
    logic        cs_n16 = 1'b1;
    logic        tready = 1'b1;
    logic [1:0]  spi_mode = 2'd0;
    logic [5:0]  ww8 = 6'd8;
    logic [5:0]  ww16 = 6'd12;

    logic [7:0]  tdata8;
    logic        tvalid8, busy8, ovf8, fe8;
    logic [15:0] tdata16;
    logic        tvalid16, busy16, ovf16, fe16;

    spi_rx #(.AXIS_DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .sclk(sclk), .rxd(rxd), .cs_n(cs_n8),
        .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tready(tready),
        .spi_mode(spi_mode), .spi_word_width(ww8),
        .busy(busy8), .overflow(ovf8), .frame_error(fe8)
    );

    spi_rx #(.AXIS_DATA_WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .sclk(sclk), .rxd(rxd), .cs_n(cs_n16),
        .m_axis_tdata(tdata16), .m_axis_tvalid(tvalid16), .m_axis_tready(tready),
        .spi_mode(spi_mode), .spi_word_width(ww16),
        .busy(busy16), .overflow(ovf16), .frame_error(fe16)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q8[$];
    logic [63:0] exp_q16[$];
    int          ovf_cnt8 = 0, ovf_cnt16 = 0, fe_cnt8 = 0, fe_cnt16 = 0;
    bit          rand_ready = 1'b0;

    typedef struct {
        logic [1:0]  mode;
        int          ww;
        int          nbits;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int eff_width(input int ww, input int dw);
        return (ww == 0 || ww > dw) ? dw : ww;
    endfunction

    function automatic logic [63:0] model_word(input logic [63:0] data, input int ww, input int dw);
        int w;
        w = eff_width(ww, dw);
        return (w >= 64) ? data : (data & ((64'd1 << w) - 64'd1));
    endfunction

    // Scoreboard: every accepted word must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (tvalid8 && tready) begin
                if (exp_q8.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL word8: got unexpected 0x%0h, expected no word", tdata8);
                end else begin
                    check("word8", {56'd0, tdata8}, exp_q8.pop_front());
                end
            end
            if (tvalid16 && tready) begin
                if (exp_q16.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL word16: got unexpected 0x%0h, expected no word", tdata16);
                end else begin
                    check("word16", {48'd0, tdata16}, exp_q16.pop_front());
                end
            end
            if (ovf8)  ovf_cnt8++;
            if (ovf16) ovf_cnt16++;
            if (fe8)   fe_cnt8++;
            if (fe16)  fe_cnt16++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) tready = 1'($urandom_range(0, 1));
        end
    end

    // Drives one frame: nbits of data MSB first, cs_n low around the bits.
    task automatic send_word(input bit sel16, input logic [1:0] mode, input int ww,
                             input int nbits, input logic [63:0] data,
                             input bit push, input bit close, input bit drain);
        int t;
        if (drain) begin
            t = 0;
            while ((tvalid8 || tvalid16) && t < 500) begin
                clk_n(1);
                t++;
            end
            if (tvalid8 || tvalid16) check("drain_timeout", 64'(tvalid8 | tvalid16), 64'd0);
        end
        if (push) begin
            if (sel16) exp_q16.push_back(model_word(data, ww, 16));
            else       exp_q8.push_back(model_word(data, ww, 8));
        end
        spi_mode = mode;
        if (sel16) ww16 = 6'(ww);
        else       ww8  = 6'(ww);
        sclk = mode[1];
        clk_n(4);
        if (sel16) cs_n16 = 1'b0;
        else       cs_n8  = 1'b0;
        clk_n(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!mode[0]) begin
                rxd = data[i];
                clk_n(4);
                sclk = ~sclk;
                clk_n(4);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                clk_n(2);
                rxd = data[i];
                clk_n(2);
                sclk = ~sclk;
                clk_n(4);
            end
        end
        clk_n(6);
        if (close) begin
            cs_n8  = 1'b1;
            cs_n16 = 1'b1;
            clk_n(4);
        end
    endtask

    initial begin
        int ovf0, fe0, sel, ww, dw;
        logic [1:0]  mode;
        logic [63:0] data;

        tbl[0] = '{2'd0, 8,  8, 64'hA5, 64'hA5};
        tbl[1] = '{2'd1, 8,  8, 64'h3C, 64'h3C};
        tbl[2] = '{2'd2, 8,  8, 64'hFF, 64'hFF};
        tbl[3] = '{2'd3, 8,  8, 64'h00, 64'h00};
        tbl[4] = '{2'd0, 0,  8, 64'h81, 64'h81};
        tbl[5] = '{2'd1, 40, 8, 64'h7E, 64'h7E};
        tbl[6] = '{2'd2, 4,  4, 64'h9,  64'h09};
        tbl[7] = '{2'd3, 1,  1, 64'h1,  64'h01};
        tbl[8] = '{2'd0, 5,  5, 64'h15, 64'h15};

        // Reset state
        rst = 1'b1;
        clk_n(3);
        check("rst_tvalid8", 64'(tvalid8), 64'd0);
        check("rst_tdata8",  64'(tdata8),  64'd0);
        check("rst_busy8",   64'(busy8),   64'd0);
        check("rst_ovf8",    64'(ovf8),    64'd0);
        check("rst_fe8",     64'(fe8),     64'd0);
        check("rst_tvalid16", 64'(tvalid16), 64'd0);
        rst = 1'b0;
        clk_n(2);

        // Table vectors on the 8-bit instance; expected values come from the table.
        for (int i = 0; i < 9; i++) begin
            exp_q8.push_back(tbl[i].exp);
            send_word(1'b0, tbl[i].mode, tbl[i].ww, tbl[i].nbits, tbl[i].data, 1'b0, 1'b1, 1'b1);
        end

        // 16-bit instance, 12-bit words, all modes
        for (int m = 0; m < 4; m++) begin
            send_word(1'b1, 2'(m), 12, 12, 64'h0ABC, 1'b1, 1'b1, 1'b1);
        end

        // Randomized frames with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sel  = int'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            ww   = int'($urandom_range(0, 63));
            data = {$urandom, $urandom};
            dw   = sel ? 16 : 8;
            send_word(sel[0], mode, ww, eff_width(ww, dw), data, 1'b1, 1'b1, 1'b1);
        end
        rand_ready = 1'b0;
        tready = 1'b1;
        clk_n(10);

        // Overflow: held word survives, second word dropped
        tready = 1'b0;
        ovf0 = ovf_cnt8;
        send_word(1'b0, 2'd0, 8, 8, 64'h11, 1'b1, 1'b1, 1'b1);
        send_word(1'b0, 2'd0, 8, 8, 64'h22, 1'b0, 1'b1, 1'b0);
        check("ovf_pulses",  64'(ovf_cnt8 - ovf0), 64'd1);
        check("ovf_held",    64'(tdata8), 64'h11);
        check("ovf_tvalid",  64'(tvalid8), 64'd1);
        tready = 1'b1;
        clk_n(3);
        check("ovf_drained", 64'(tvalid8), 64'd0);
        send_word(1'b0, 2'd0, 8, 8, 64'h33, 1'b1, 1'b1, 1'b1);

        // Frame error: 3 bits then cs_n rises
        fe0 = fe_cnt8;
        send_word(1'b0, 2'd0, 8, 3, 64'h5, 1'b0, 1'b1, 1'b1);
        clk_n(4);
        check("fe_pulses",  64'(fe_cnt8 - fe0), 64'd1);
        check("fe_tvalid",  64'(tvalid8), 64'd0);
        check("fe_busy",    64'(busy8), 64'd0);
        send_word(1'b0, 2'd0, 8, 8, 64'h5A, 1'b1, 1'b1, 1'b1);

        // Reset mid-word discards both partial and held words
        tready = 1'b0;
        send_word(1'b0, 2'd0, 8, 8, 64'h11, 1'b0, 1'b1, 1'b1);
        send_word(1'b0, 2'd0, 8, 4, 64'hC, 1'b0, 1'b0, 1'b0);
        check("mid_busy",   64'(busy8), 64'd1);
        check("mid_tvalid", 64'(tvalid8), 64'd1);
        rst = 1'b1;
        clk_n(2);
        check("rst2_tvalid", 64'(tvalid8), 64'd0);
        check("rst2_tdata",  64'(tdata8),  64'd0);
        check("rst2_busy",   64'(busy8),   64'd0);
        rst = 1'b0;
        cs_n8 = 1'b1;
        tready = 1'b1;
        clk_n(4);
        check("post_rst_tvalid", 64'(tvalid8), 64'd0);
        check("post_rst_ovf",    64'(ovf8),    64'd0);
        check("post_rst_fe",     64'(fe8),     64'd0);
        send_word(1'b0, 2'd0, 8, 8, 64'hC3, 1'b1, 1'b1, 1'b1);
        clk_n(20);

        check("q8_empty",     64'(exp_q8.size()),  64'd0);
        check("q16_empty",    64'(exp_q16.size()), 64'd0);
        check("ovf8_total",   64'(ovf_cnt8),  64'd1);
        check("ovf16_total",  64'(ovf_cnt16), 64'd0);
        check("fe8_total",    64'(fe_cnt8),   64'd1);
        check("fe16_total",   64'(fe_cnt16),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
